stopwatch_bcd: RTL and testbench
================================

# stopwatch_bcd

MM:SS stopwatch that consumes the one-cycle tick produced by the rate divider and counts elapsed ticks in BCD. It provides start/stop, clear and lap-hold controls driven from raw push-button levels. It sits between the rate divider (tick source) and the seven-segment decoders (digit sink).

## Interface

- SATURATE, default 0: 0 = wrap 59:59 to 00:00 and keep running; 1 = stop at 59:59.
- ClockIn  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high; highest priority.
- Tick  input  1  advance enable from the rate divider, sampled at posedge; may be high on consecutive cycles.
- StartStop  input  1  level; rising edge toggles run/pause.
- Clear  input  1  level; rising edge returns to 00:00, stopped.
- LapHold  input  1  level; while high, Display is frozen while counting continues.
- Display  output  16  {MinTens, MinOnes, SecTens, SecOnes}, 4-bit BCD each.
- Running  output  1  high in RUNNING state.
- Overflow  output  1  one-cycle pulse on the 59:59 rollover/saturation event.

## Operation

- Internal registers:
  - Count: 4 BCD digits.
  - LapReg: 16 bits.
  - State: IDLE, RUNNING or PAUSED.
  - PrevStart, PrevClear, PrevLap: edge-detect history.
- Edge detect: edge = input & ~prev. The prev registers reset to 1, so an input held high through reset release produces no edge.
- Priority each cycle: Reset > Clear edge > StartStop edge / Tick.
- Clear edge, any state:
  - State → IDLE; Count → 0; LapReg → 0.
  - A StartStop edge in the same cycle is ignored.
- FSM on StartStop edge:
  - IDLE→RUNNING.
  - RUNNING→PAUSED.
  - PAUSED→RUNNING.
- Increment rule: Count increments iff the current State register is RUNNING and Tick=1.
  - A tick coinciding with the start edge is not counted.
  - A tick coinciding with the pause edge is counted.
- Digit arithmetic, cascaded:
  - SecOnes 0-9; its carry feeds SecTens 0-5.
  - SecTens carry feeds MinOnes 0-9.
  - MinOnes carry feeds MinTens 0-5.
  - Digits never hold non-BCD values.
- Terminal count 59:59 with increment:
  - SATURATE=0: Count → 00:00, State stays RUNNING, Overflow=1 next cycle.
  - SATURATE=1: Count stays 59:59, State → PAUSED, Overflow=1 next cycle.
  - A later StartStop edge from PAUSED at 59:59 with SATURATE=1 resumes RUNNING; the next tick saturates again with another Overflow pulse.
- Lap:
  - LapHold rising edge loads LapReg with the current Count, i.e. the pre-increment value of that cycle.
  - Display = LapHold ? LapReg : Count (combinational mux).
  - Counting is unaffected by LapHold.
  - Clear while LapHold is high zeroes both Count and LapReg, so Display shows 00:00.

## Timing

- Reset values: Display 0x0000, Running 0, Overflow 0, State IDLE, Count 0, LapReg 0, prev registers 1.
- Control latency: an edge seen in cycle N takes effect at the posedge ending cycle N. For example, Running rises in cycle N+1.
- Tick-to-Display latency: 1 cycle (Count register), when LapHold is low.
- Overflow: registered pulse, exactly 1 cycle wide, in the cycle after the terminal increment.
- Back-to-back ticks (Tick tied high) increment every cycle with no dropped counts.
- Reset mid-count or mid-lap: all state returns to reset values on the next posedge, regardless of other inputs.

## Test plan

- Reset, pulse StartStop, apply 75 ticks → Display=0x0115 (01:15), Running=1.
- From RUNNING, StartStop edge coincident with a tick, then 10 more ticks → count includes the coincident tick; count is frozen afterwards; Running=0.
- SATURATE=0, preload to 59:58 via ticks, 3 ticks → 59:59, 00:00, 00:01; Overflow high for exactly 1 cycle after 00:00 is reached; Running stays 1.
- SATURATE=1, run to 59:59, 2 more ticks → Display stays 0x5959; Running=0; one Overflow pulse.
- LapHold raised at 00:30, 20 ticks, LapHold dropped → Display shows 0x0030 while held, then 0x0050.
- Clear and StartStop rising together while RUNNING at 02:10 → Display=0x0000, Running=0. Repeat with StartStop held high through Reset → no start after reset.

Source files
------------

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : MM:SS BCD stopwatch advanced by the one-cycle tick from the
//                rate divider. It has start/stop, clear and lap-hold controls,
//                and each control is edge-detected from a raw push-button
//                level.
//  Ports       : ClockIn   - system clock, all state changes on posedge
//                Reset     - synchronous active-high reset, highest priority
//                Tick      - advance enable, may be high on consecutive cycles
//                StartStop - level, rising edge toggles run/pause
//                Clear     - level, rising edge returns to 00:00 stopped
//                LapHold   - level, while high Display shows the lap snapshot
//                Display   - {MinTens, MinOnes, SecTens, SecOnes} BCD digits
//                Running   - high while in the RUNNING state
//                Overflow  - one-cycle pulse after the 59:59 terminal event
//  Parameters  : SATURATE  - 0 wraps 59:59 to 00:00, 1 stops at 59:59
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd #(
    parameter bit SATURATE = 1'b0
) (
    input  logic        ClockIn,
    input  logic        Reset,
    input  logic        Tick,
    input  logic        StartStop,
    input  logic        Clear,
    input  logic        LapHold,
    output logic [15:0] Display,
    output logic        Running,
    output logic        Overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [3:0]  r_sec_ones;
    logic [3:0]  r_sec_tens;
    logic [3:0]  r_min_ones;
    logic [3:0]  r_min_tens;
    logic [15:0] r_lap;
    logic        r_overflow;

    // Edge-detect history resets to 1 so that a button held through reset
    // release does not register as a press.
    logic        r_prev_start;
    logic        r_prev_clear;
    logic        r_prev_lap;

    logic        w_start_edge;
    logic        w_clear_edge;
    logic        w_lap_edge;
    logic        w_inc;
    logic        w_terminal;
    logic [15:0] w_count;

    logic        w_so_wrap;
    logic        w_st_wrap;
    logic        w_mo_wrap;
    logic [3:0]  w_sec_ones_next;
    logic [3:0]  w_sec_tens_next;
    logic [3:0]  w_min_ones_next;
    logic [3:0]  w_min_tens_next;

    assign w_start_edge = StartStop & ~r_prev_start;
    assign w_clear_edge = Clear     & ~r_prev_clear;
    assign w_lap_edge   = LapHold   & ~r_prev_lap;

    assign w_count    = {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};

    // Only the registered state gates counting: a tick in the same cycle as
    // the start edge is not counted, one coincident with the pause edge is.
    assign w_inc      = (r_state == ST_RUNNING) && Tick;
    assign w_terminal = (w_count == 16'h5959);

    assign w_so_wrap  = (r_sec_ones == 4'd9);
    assign w_st_wrap  = (r_sec_tens == 4'd5);
    assign w_mo_wrap  = (r_min_ones == 4'd9);

    // Cascaded BCD increment; each digit advances only when every lower
    // digit is at its maximum. The 59:59 case is handled separately below.
    always_comb begin
        w_sec_ones_next = w_so_wrap ? 4'd0 : r_sec_ones + 4'd1;
        w_sec_tens_next = r_sec_tens;
        w_min_ones_next = r_min_ones;
        w_min_tens_next = r_min_tens;
        if (w_so_wrap) begin
            w_sec_tens_next = w_st_wrap ? 4'd0 : r_sec_tens + 4'd1;
            if (w_st_wrap) begin
                w_min_ones_next = w_mo_wrap ? 4'd0 : r_min_ones + 4'd1;
                if (w_mo_wrap) begin
                    w_min_tens_next = (r_min_tens == 4'd5) ? 4'd0 : r_min_tens + 4'd1;
                end
            end
        end
    end

    // Next-state logic. Clear overrides any StartStop edge in the same
    // cycle, and saturation forces PAUSED even if a pause edge is present.
    always_comb begin
        w_state_next = r_state;
        if (w_clear_edge) begin
            w_state_next = ST_IDLE;
        end else begin
            if (w_start_edge) begin
                case (r_state)
                    ST_IDLE:    w_state_next = ST_RUNNING;
                    ST_RUNNING: w_state_next = ST_PAUSED;
                    ST_PAUSED:  w_state_next = ST_RUNNING;
                    default:    w_state_next = ST_IDLE;
                endcase
            end
            if (SATURATE && w_inc && w_terminal) begin
                w_state_next = ST_PAUSED;
            end
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_prev_start <= 1'b1;
            r_prev_clear <= 1'b1;
            r_prev_lap   <= 1'b1;
        end else begin
            r_prev_start <= StartStop;
            r_prev_clear <= Clear;
            r_prev_lap   <= LapHold;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset || w_clear_edge) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_min_ones <= 4'd0;
            r_min_tens <= 4'd0;
        end else if (w_inc) begin
            if (w_terminal) begin
                // Saturating mode keeps 59:59; wrapping mode returns to 00:00.
                if (!SATURATE) begin
                    r_sec_ones <= 4'd0;
                    r_sec_tens <= 4'd0;
                    r_min_ones <= 4'd0;
                    r_min_tens <= 4'd0;
                end
            end else begin
                r_sec_ones <= w_sec_ones_next;
                r_sec_tens <= w_sec_tens_next;
                r_min_ones <= w_min_ones_next;
                r_min_tens <= w_min_tens_next;
            end
        end
    end

    // Overflow is suppressed when Clear wins the cycle, since no terminal
    // increment actually takes place then.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= ~w_clear_edge & w_inc & w_terminal;
        end
    end

    // The lap snapshot captures the pre-increment count of the edge cycle.
    always_ff @(posedge ClockIn) begin
        if (Reset || w_clear_edge) begin
            r_lap <= 16'h0000;
        end else if (w_lap_edge) begin
            r_lap <= w_count;
        end
    end

    assign Display  = LapHold ? r_lap : w_count;
    assign Running  = (r_state == ST_RUNNING);
    assign Overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_bcd
//  Description : Directed self-checking bench for stopwatch_bcd. It drives a
//                wrapping and a saturating instance from shared inputs and
//                compares their outputs against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_bcd;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic        lap_hold;

    logic [15:0] disp_w;
    logic        run_w;
    logic        ovf_w;
    logic [15:0] disp_s;
    logic        run_s;
    logic        ovf_s;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_bcd #(.SATURATE(1'b0)) u_dut_wrap (
        .ClockIn   (clk),
        .Reset     (rst),
        .Tick      (tick),
        .StartStop (start_stop),
        .Clear     (clear),
        .LapHold   (lap_hold),
        .Display   (disp_w),
        .Running   (run_w),
        .Overflow  (ovf_w)
    );

    stopwatch_bcd #(.SATURATE(1'b1)) u_dut_sat (
        .ClockIn   (clk),
        .Reset     (rst),
        .Tick      (tick),
        .StartStop (start_stop),
        .Clear     (clear),
        .LapHold   (lap_hold),
        .Display   (disp_s),
        .Running   (run_s),
        .Overflow  (ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap_hold = 1'b0;
        step(2);
        rst = 1'b0;
        check("reset_display", disp_w, 16'h0000);
        check("reset_running", {15'd0, run_w}, 16'd0);
        check("reset_overflow", {15'd0, ovf_w}, 16'd0);
        step(1);

        // Start, then 75 ticks -> 01:15
        start_stop = 1'b1; step(1);
        check("start_running", {15'd0, run_w}, 16'd1);
        start_stop = 1'b0;
        tick = 1'b1; step(75);
        tick = 1'b0;
        check("count_75", disp_w, 16'h0115);
        check("count_75_running", {15'd0, run_w}, 16'd1);

        // Pause edge coincident with a tick: that tick counts, later ones do not
        start_stop = 1'b1; tick = 1'b1; step(1);
        check("pause_tick_counted", disp_w, 16'h0116);
        start_stop = 1'b0; step(10);
        tick = 1'b0;
        check("paused_frozen", disp_w, 16'h0116);
        check("paused_running", {15'd0, run_w}, 16'd0);

        // Resume; a tick at the resume edge is not counted
        start_stop = 1'b1; tick = 1'b1; step(1);
        check("resume_tick_ignored", disp_w, 16'h0116);
        check("resume_running", {15'd0, run_w}, 16'd1);
        start_stop = 1'b0;
        step(3522);   // 76 s + 3522 = 3598 s = 59:58
        check("pre_terminal_w", disp_w, 16'h5958);
        check("pre_terminal_s", disp_s, 16'h5958);
        step(1);
        check("terminal_w", disp_w, 16'h5959);
        check("terminal_ovf_w", {15'd0, ovf_w}, 16'd0);
        step(1);
        check("wrap_display", disp_w, 16'h0000);
        check("wrap_ovf", {15'd0, ovf_w}, 16'd1);
        check("wrap_running", {15'd0, run_w}, 16'd1);
        check("sat_display", disp_s, 16'h5959);
        check("sat_ovf", {15'd0, ovf_s}, 16'd1);
        check("sat_running", {15'd0, run_s}, 16'd0);
        step(1);
        check("wrap_next", disp_w, 16'h0001);
        check("wrap_ovf_off", {15'd0, ovf_w}, 16'd0);
        check("sat_hold", disp_s, 16'h5959);
        check("sat_ovf_off", {15'd0, ovf_s}, 16'd0);
        tick = 1'b0; step(1);

        // Resume saturated instance; the next tick saturates again
        start_stop = 1'b1; step(1);
        check("sat_resume", {15'd0, run_s}, 16'd1);
        start_stop = 1'b0; tick = 1'b1; step(1);
        tick = 1'b0;
        check("sat_again_display", disp_s, 16'h5959);
        check("sat_again_ovf", {15'd0, ovf_s}, 16'd1);
        check("sat_again_running", {15'd0, run_s}, 16'd0);
        check("wrap_paused_hold", disp_w, 16'h0001);
        step(1);
        check("sat_again_ovf_off", {15'd0, ovf_s}, 16'd0);

        // Clear then lap test
        clear = 1'b1; step(1);
        check("clear_display", disp_w, 16'h0000);
        check("clear_running", {15'd0, run_w}, 16'd0);
        clear = 1'b0; step(1);
        start_stop = 1'b1; step(1);
        start_stop = 1'b0;
        tick = 1'b1; step(30);
        tick = 1'b0;
        check("lap_pre", disp_w, 16'h0030);
        lap_hold = 1'b1; step(1);
        tick = 1'b1; step(20);
        tick = 1'b0;
        check("lap_held", disp_w, 16'h0030);
        lap_hold = 1'b0; step(1);
        check("lap_released", disp_w, 16'h0050);

        // Clear and StartStop together while running at 02:10
        tick = 1'b1; step(80);
        tick = 1'b0;
        check("at_0210", disp_w, 16'h0210);
        clear = 1'b1; start_stop = 1'b1; step(1);
        check("clr_start_display", disp_w, 16'h0000);
        check("clr_start_running", {15'd0, run_w}, 16'd0);
        clear = 1'b0; step(2);
        check("held_start_no_edge", {15'd0, run_w}, 16'd0);

        // StartStop held high through reset release gives no start
        rst = 1'b1; step(1);
        rst = 1'b0; step(3);
        check("reset_held_start", {15'd0, run_w}, 16'd0);
        start_stop = 1'b0; step(1);
        start_stop = 1'b1; step(1);
        check("fresh_start", {15'd0, run_w}, 16'd1);
        start_stop = 1'b0;

        // Clear while LapHold high zeroes the shown value
        tick = 1'b1; step(5);
        tick = 1'b0;
        lap_hold = 1'b1; step(1);
        tick = 1'b1; step(3);
        tick = 1'b0;
        check("lap2_held", disp_w, 16'h0005);
        clear = 1'b1; step(1);
        check("clear_in_lap", disp_w, 16'h0000);
        check("clear_in_lap_run", {15'd0, run_w}, 16'd0);
        clear = 1'b0; lap_hold = 1'b0; step(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
